// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_rs_data,
  input  logic [XLEN-1:0]   id_rt_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [CTRL_W-1:0] id_alu_control,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] ex_alu_control,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              load_use_stall
);
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   imm;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic [CTRL_W-1:0] alu_control;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } stage_t;
  stage_t q, d;
  logic bubble;
  logic [XLEN-1:0] fwd_rs, fwd_rt;
  always_comb begin
    d = '{valid:       id_valid,
          rs_data:     id_rs_data,
          rt_data:     id_rt_data,
          imm:         id_imm,
          rs:          id_rs,
          rt:          id_rt,
          rd:          id_rd,
          alu_control: id_alu_control,
          alu_src:     id_alu_src,
          reg_write:   id_reg_write & id_valid,
          mem_read:    id_mem_read & id_valid,
          mem_write:   id_mem_write & id_valid,
          mem_to_reg:  id_mem_to_reg & id_valid};
  end
  assign load_use_stall = q.valid & q.mem_read & (q.rd != '0) & id_valid &
                          ((q.rd == id_rs) | (q.rd == id_rt));
  // a bubble zeroes the whole stage, so no stale data leaks into EX
  assign bubble = flush | (~stall & load_use_stall);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (bubble) q <= '0;
    else if (!stall) q <= d;
  end
  // forwarding is applied to the held operands every cycle, including while stalled
  always_comb begin
    fwd_rs = (exmem_reg_write && exmem_rd != '0 && exmem_rd == q.rs) ? exmem_result :
             (memwb_reg_write && memwb_rd != '0 && memwb_rd == q.rs) ? memwb_result : q.rs_data;
    fwd_rt = (exmem_reg_write && exmem_rd != '0 && exmem_rd == q.rt) ? exmem_result :
             (memwb_reg_write && memwb_rd != '0 && memwb_rd == q.rt) ? memwb_result : q.rt_data;
  end
  assign alu_a          = fwd_rs;
  assign alu_b          = q.alu_src ? q.imm : fwd_rt;
  assign ex_store_data  = fwd_rt;
  assign ex_valid       = q.valid;
  assign ex_alu_control = q.alu_control;
  assign ex_rd          = q.rd;
  assign ex_reg_write   = q.reg_write;
  assign ex_mem_read    = q.mem_read;
  assign ex_mem_write   = q.mem_write;
  assign ex_mem_to_reg  = q.mem_to_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, forwarding, load-use, stall/flush and reset
module tb_id_ex_stage;
  logic clk = 0, rst_n = 0, stall = 0, flush = 0, id_valid = 0;
  logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic [3:0] id_alu_control = 0;
  logic id_alu_src = 0, id_reg_write = 0, id_mem_read = 0, id_mem_write = 0, id_mem_to_reg = 0;
  logic [4:0] exmem_rd = 0, memwb_rd = 0;
  logic exmem_reg_write = 0, memwb_reg_write = 0;
  logic [31:0] exmem_result = 0, memwb_result = 0;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0] ex_alu_control;
  logic [4:0] ex_rd;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .ex_alu_control(ex_alu_control),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .load_use_stall(load_use_stall)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [3:0] ctl, input logic src,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
    id_valid = v; id_rs_data = a; id_rt_data = b; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alu_control = ctl; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask
  task automatic no_bypass();
    exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
  endtask
  initial begin
    tick(); tick();
    #2 rst_n = 1;
    chk("reset_valid", ex_valid, 0);
    chk("reset_ctl", ex_alu_control, 0);
    // basic capture
    set_id(1, 5, 7, 0, 1, 2, 3, 4'b0010, 0, 1, 0, 0, 0);
    tick();
    chk("cap_valid", ex_valid, 1);
    chk("cap_a", alu_a, 5);
    chk("cap_b", alu_b, 7);
    chk("cap_ctl", ex_alu_control, 4'b0010);
    chk("cap_rd", ex_rd, 3);
    chk("cap_rw", ex_reg_write, 1);
    chk("cap_sd", ex_store_data, 7);
    // invalid ID slot never writes
    set_id(0, 1, 1, 0, 1, 2, 3, 4'b0010, 0, 1, 1, 1, 1);
    tick();
    chk("inv_valid", ex_valid, 0);
    chk("inv_rw", ex_reg_write, 0);
    chk("inv_mw", ex_mem_write, 0);
    // forwarding priority
    set_id(1, 32'h11, 32'h22, 0, 3, 5, 6, 4'b0010, 0, 1, 0, 0, 0);
    tick();
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'hAA;
    memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'hBB;
    #1 chk("fwd_both_a", alu_a, 32'hAA);
    chk("fwd_none_b", alu_b, 32'h22);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb_a", alu_a, 32'hBB);
    memwb_reg_write = 0;
    #1 chk("fwd_off_a", alu_a, 32'h11);
    memwb_rd = 5; memwb_reg_write = 1;
    #1 chk("fwd_memwb_b", alu_b, 32'hBB);
    chk("fwd_memwb_sd", ex_store_data, 32'hBB);
    no_bypass();
    // register 0 is never forwarded
    set_id(1, 32'h33, 32'h44, 0, 0, 0, 7, 4'b0001, 0, 1, 0, 0, 0);
    tick();
    exmem_reg_write = 1; memwb_reg_write = 1;
    #1 chk("r0_a", alu_a, 32'h33);
    chk("r0_b", alu_b, 32'h44);
    no_bypass();
    // load-use: lw into r4 in EX, consumer of r4 in ID
    set_id(1, 32'h1, 32'h2, 32'h8, 1, 2, 4, 4'b0010, 1, 1, 1, 0, 1);
    tick();
    chk("lw_mr", ex_mem_read, 1);
    set_id(1, 32'h50, 32'h60, 0, 4, 7, 8, 4'b0110, 0, 1, 0, 0, 0);
    #1 chk("lu_flag", load_use_stall, 1);
    id_valid = 0;
    #1 chk("lu_invalid_id", load_use_stall, 0);
    id_valid = 1;
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rw", ex_reg_write, 0);
    chk("lu_clear", load_use_stall, 0);
    tick();
    chk("lu_retry_rd", ex_rd, 8);
    chk("lu_retry_a", alu_a, 32'h50);
    // stall holds for 3 cycles even as ID changes
    stall = 1;
    set_id(1, 32'h99, 32'h98, 0, 9, 10, 11, 4'b0000, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rd", ex_rd, 8);
      chk("stall_a", alu_a, 32'h50);
    end
    exmem_rd = 4; exmem_reg_write = 1; exmem_result = 32'h77;
    #1 chk("stall_fwd_live", alu_a, 32'h77);
    no_bypass();
    flush = 1;
    tick();
    chk("flush_stall_valid", ex_valid, 0);
    chk("flush_stall_rw", ex_reg_write, 0);
    flush = 0; stall = 0;
    // immediate operand with forwarded store data
    set_id(1, 32'h10, 32'h20, 32'hFFFFFFFC, 1, 6, 2, 4'b0010, 1, 0, 0, 1, 0);
    tick();
    exmem_rd = 6; exmem_reg_write = 1; exmem_result = 32'hCAFE;
    #1 chk("imm_b", alu_b, 32'hFFFFFFFC);
    chk("imm_sd", ex_store_data, 32'hCAFE);
    chk("imm_mw", ex_mem_write, 1);
    no_bypass();
    // async reset mid-cycle while stalled
    stall = 1;
    #3 rst_n = 0;
    #1 chk("arst_valid", ex_valid, 0);
    chk("arst_a", alu_a, 0);
    chk("arst_b", alu_b, 0);
    chk("arst_ctl", ex_alu_control, 0);
    chk("arst_mw", ex_mem_write, 0);
    tick();
    #2 rst_n = 1; stall = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
